// File: rtl/si4463_pkg.sv
// Shared opcodes, CTS status bytes and FSM states for the Si4463 host-interface responder.
package si4463_pkg;

    localparam logic [7:0] OP_POWER_UP       = 8'h02;
    localparam logic [7:0] OP_READ_CMD_BUFF  = 8'h44;
    localparam logic [7:0] OP_WRITE_TX_FIFO  = 8'h66;
    localparam logic [7:0] OP_READ_RX_FIFO   = 8'h77;
    localparam logic [7:0] CTS_READY         = 8'hFF;
    localparam logic [7:0] CTS_BUSY          = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        CAPT,
        RDBUF,
        TXF,
        RXF
    } state_t;

endpackage

// File: rtl/si4463_spi_responder_shifter.sv
// SPI mode-0 slave front end: pin synchronisers, edge detect, bit counter and shift registers.
module spi_slave_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       en,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       frame_start,
    output logic       frame_end
);
    // [1] is the synchronised value, [2] its previous cycle for edge detection
    logic [2:0] ss_q, sclk_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       sel, sclk_rise, sclk_fall;

    assign sel         = ~ss_q[1];
    assign frame_start = ss_q[2] & ~ss_q[1];
    assign frame_end   = ~ss_q[2] & ss_q[1];
    assign sclk_rise   = ~sclk_q[2] & sclk_q[1] & sel;
    assign sclk_fall   = sclk_q[2] & ~sclk_q[1] & sel;
    assign byte_done   = sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte     = {rx_sr, mosi_q[1]};

    // ss_n resets low so a reset mid-frame cannot fake a fall on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], ss_n};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
        end else if (frame_start || frame_end) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= rx_byte[6:0];
        end
    end

    // At frame start the MSB goes straight to miso; later loads wait for the next fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sr <= '0;
            miso  <= 1'b0;
        end else if (tx_load && frame_start) begin
            miso  <= tx_byte[7];
            tx_sr <= {tx_byte[6:0], 1'b0};
        end else if (tx_load) begin
            tx_sr <= tx_byte;
        end else if (!en) begin
            miso  <= 1'b0;
        end else if (sclk_fall) begin
            miso  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/si4463_spi_responder.sv
// Si4463 host-interface model: command capture, CTS/READ_CMD_BUFF handshake and TX/RX FIFO streaming.
module si4463_spi_responder
    import si4463_pkg::*;
#(
    parameter int         CMD_DEPTH    = 16,
    parameter logic [7:0] CMD_READ_BUF = OP_READ_CMD_BUFF,
    parameter logic [7:0] CMD_TX_FIFO  = OP_WRITE_TX_FIFO,
    parameter logic [7:0] CMD_RX_FIFO  = OP_READ_RX_FIFO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       cmd_valid,
    output logic [4:0] cmd_len,
    input  logic [3:0] cmd_rd_addr,
    output logic [7:0] cmd_rd_data,
    input  logic       resp_wr,
    input  logic [3:0] resp_addr,
    input  logic [7:0] resp_data,
    input  logic       resp_done,
    output logic       cts,
    output logic       txf_wr,
    output logic [7:0] txf_data,
    output logic       rxf_rd,
    input  logic [7:0] rxf_data,
    output logic       err_ovf
);
    state_t state, nxt;

    logic [CMD_DEPTH-1:0][7:0] cmd_buf, resp_buf;
    logic [4:0] cmd_cnt;
    logic [3:0] rd_idx;
    logic       rd_ok;
    logic       byte_done, frame_start, frame_end;
    logic [7:0] rx_byte, tx_byte;
    logic       tx_load, cap_wr, cap_store, cts_clr, txf_pulse, rxf_pulse, rd_start;

    spi_slave_shifter u_shift (
        .clk         (clk),
        .reset       (reset),
        .ss_n        (ss_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .en          (state != IDLE),
        .tx_load     (tx_load),
        .tx_byte     (tx_byte),
        .miso        (miso),
        .byte_done   (byte_done),
        .rx_byte     (rx_byte),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign cmd_rd_data = cmd_buf[cmd_rd_addr];
    assign cap_store   = cap_wr && (cmd_cnt < 5'(CMD_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt       = state;
        tx_load   = 1'b0;
        tx_byte   = CTS_BUSY;
        cap_wr    = 1'b0;
        cts_clr   = 1'b0;
        txf_pulse = 1'b0;
        rxf_pulse = 1'b0;
        rd_start  = 1'b0;
        case (state)
            IDLE: if (frame_start) begin
                nxt     = OPCODE;
                tx_load = 1'b1;
            end
            OPCODE: if (byte_done) begin
                tx_load = 1'b1;
                if (rx_byte == CMD_READ_BUF) begin
                    nxt      = RDBUF;
                    rd_start = 1'b1;
                    tx_byte  = cts ? CTS_READY : CTS_BUSY;
                end else if (rx_byte == CMD_TX_FIFO) begin
                    nxt = TXF;
                end else if (rx_byte == CMD_RX_FIFO) begin
                    nxt       = RXF;
                    tx_byte   = rxf_data;
                    rxf_pulse = 1'b1;
                end else begin
                    nxt     = CAPT;
                    cap_wr  = 1'b1;
                    cts_clr = 1'b1;
                end
            end
            CAPT: if (byte_done) begin
                tx_load = 1'b1;
                cap_wr  = 1'b1;
            end
            RDBUF: if (byte_done) begin
                tx_load = 1'b1;
                tx_byte = rd_ok ? resp_buf[rd_idx] : CTS_BUSY;
            end
            TXF: if (byte_done) begin
                tx_load   = 1'b1;
                txf_pulse = 1'b1;
            end
            RXF: if (byte_done) begin
                tx_load   = 1'b1;
                tx_byte   = rxf_data;
                rxf_pulse = 1'b1;
            end
            default: nxt = IDLE;
        endcase
        if (frame_end) nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd_len   <= '0;
            cts       <= 1'b1;
            err_ovf   <= 1'b0;
            rd_idx    <= '0;
            rd_ok     <= 1'b0;
            txf_wr    <= 1'b0;
            txf_data  <= '0;
            rxf_rd    <= 1'b0;
        end else begin
            cmd_valid <= (state == CAPT) && frame_end;
            txf_wr    <= txf_pulse;
            rxf_rd    <= rxf_pulse;
            if (frame_start) cmd_cnt <= '0;
            else if (cap_store) cmd_cnt <= cmd_cnt + 5'd1;
            if (cap_wr && !cap_store) err_ovf <= 1'b1;
            if ((state == CAPT) && frame_end) cmd_len <= cmd_cnt;
            // clear on capture entry takes priority over a coincident resp_done
            if (cts_clr) cts <= 1'b0;
            else if (resp_done) cts <= 1'b1;
            if (rd_start) begin
                rd_idx <= '0;
                rd_ok  <= cts;
            end else if (state == RDBUF && byte_done) begin
                rd_idx <= rd_idx + 4'd1;
            end
            if (txf_pulse) txf_data <= rx_byte;
        end
    end

    // Buffers hold their contents across reset
    always_ff @(posedge clk) begin
        if (cap_store) cmd_buf[cmd_cnt[3:0]] <= rx_byte;
        if (resp_wr)   resp_buf[resp_addr]   <= resp_data;
    end

endmodule

// File: tb/tb_si4463_spi_responder.sv
// Directed bench: an SPI mode-0 master drives the responder frame by frame and checks hand-computed results.
module tb_si4463_spi_responder;
    localparam int H = 8;  // clk cycles per SCLK half-period

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0, reset, ss_n, sclk, mosi, miso, cmd_valid;
    logic [4:0] cmd_len;
    logic [3:0] cmd_rd_addr, resp_addr;
    logic [7:0] cmd_rd_data, resp_data, txf_data, rxf_data;
    logic       resp_wr, resp_done, cts, txf_wr, rxf_rd, err_ovf;

    int n_vec = 0, n_bad = 0, n_valid = 0, n_rxrd = 0, rxf_i = 0;
    logic [7:0] txq[$];
    logic [7:0] rxf_src[3] = '{8'h5A, 8'hA5, 8'h00};

    si4463_spi_responder dut (
        .clk(clk), .reset(reset), .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_rd_addr(cmd_rd_addr),
        .cmd_rd_data(cmd_rd_data), .resp_wr(resp_wr), .resp_addr(resp_addr),
        .resp_data(resp_data), .resp_done(resp_done), .cts(cts), .txf_wr(txf_wr),
        .txf_data(txf_data), .rxf_rd(rxf_rd), .rxf_data(rxf_data), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Event monitor; also plays the RX FIFO, advancing rxf_data on each rxf_rd
    always @(negedge clk) begin
        if (txf_wr) txq.push_back(txf_data);
        if (cmd_valid) n_valid++;
        if (rxf_rd) begin
            n_rxrd++;
            if (rxf_i < 2) rxf_i++;
            rxf_data = rxf_src[rxf_i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            repeat (H) @(negedge clk);
            r[7-i] = miso;
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input bq_t tx, output bq_t rx);
        logic [7:0] r;
        rx = {};
        ss_n = 1'b0;
        repeat (H) @(negedge clk);
        foreach (tx[i]) begin
            spi_bits(tx[i], 8, r);
            rx.push_back(r);
        end
        repeat (H) @(negedge clk);
        ss_n = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t tx, rx;
        logic [7:0] r0, r1, r2;
        int base, mid;
        logic [7:0] exp_tx[3] = '{8'h11, 8'h22, 8'h33};

        reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cmd_rd_addr = '0; resp_wr = 1'b0; resp_addr = '0; resp_data = '0;
        resp_done = 1'b0; rxf_data = rxf_src[0];
        repeat (4) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_len", cmd_len, 0);
        chk("rst_cts", cts, 1);
        chk("rst_txf_wr", txf_wr, 0);
        chk("rst_txf_data", txf_data, 0);
        chk("rst_rxf_rd", rxf_rd, 0);
        chk("rst_err_ovf", err_ovf, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // POWER_UP capture
        xfer('{8'h02, 8'h01, 8'h00, 8'h01, 8'hC9, 8'hC3, 8'h80}, rx);
        chk("pu_valid_cnt", n_valid, 1);
        chk("pu_cmd_len", cmd_len, 7);
        chk("pu_cts", cts, 0);
        cmd_rd_addr = 4'd4; @(negedge clk);
        chk("pu_byte4", cmd_rd_data, 8'hC9);
        cmd_rd_addr = 4'd0; @(negedge clk);
        chk("pu_byte0", cmd_rd_data, 8'h02);
        chk("pu_no_txf", txq.size(), 0);

        // READ_CMD_BUFF while busy
        xfer('{8'h44, 8'h00, 8'h00}, rx);
        chk("busy_b0", rx[0], 8'h00);
        chk("busy_cts", rx[1], 8'h00);
        chk("busy_b2", rx[2], 8'h00);

        // Load response, signal done, read it back
        resp_wr = 1'b1; resp_addr = 4'd0; resp_data = 8'hAA; @(negedge clk);
        resp_addr = 4'd1; resp_data = 8'hBB; @(negedge clk);
        resp_wr = 1'b0; resp_done = 1'b1; @(negedge clk);
        resp_done = 1'b0; @(negedge clk);
        chk("done_cts", cts, 1);
        xfer('{8'h44, 8'h00, 8'h00, 8'h00}, rx);
        chk("rd_b0", rx[0], 8'h00);
        chk("rd_cts", rx[1], 8'hFF);
        chk("rd_resp0", rx[2], 8'hAA);
        chk("rd_resp1", rx[3], 8'hBB);
        chk("rd_cts_after", cts, 1);

        // WRITE_TX_FIFO
        base = n_valid;
        xfer('{8'h66, 8'h11, 8'h22, 8'h33}, rx);
        chk("txf_count", txq.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("txf_data", (i < txq.size()) ? txq[i] : 8'hEE, exp_tx[i]);
        chk("txf_no_valid", n_valid - base, 0);
        txq = {};

        // WRITE_TX_FIFO aborted mid-byte
        ss_n = 1'b0; repeat (H) @(negedge clk);
        spi_bits(8'h66, 8, r0);
        spi_bits(8'h55, 4, r0);
        repeat (H) @(negedge clk); ss_n = 1'b1; repeat (2*H) @(negedge clk);
        chk("txf_partial", txq.size(), 0);

        // READ_RX_FIFO
        base = n_rxrd;
        ss_n = 1'b0; repeat (H) @(negedge clk);
        spi_bits(8'h77, 8, r0);
        spi_bits(8'h00, 8, r1);
        mid = n_rxrd - base;
        spi_bits(8'h00, 8, r2);
        repeat (H) @(negedge clk); ss_n = 1'b1; repeat (2*H) @(negedge clk);
        chk("rxf_b1", r1, 8'h5A);
        chk("rxf_b2", r2, 8'hA5);
        chk("rxf_rd_fed", mid, 2);

        // Over-long command
        base = n_valid;
        tx = {};
        for (int i = 0; i < 20; i++) tx.push_back(8'(8'h10 + i));
        xfer(tx, rx);
        chk("ovf_valid", n_valid - base, 1);
        chk("ovf_cmd_len", cmd_len, 16);
        chk("ovf_err", err_ovf, 1);
        cmd_rd_addr = 4'd15; @(negedge clk);
        chk("ovf_last", cmd_rd_data, 8'h1F);

        // Reset 12 bits into a frame
        ss_n = 1'b0; repeat (H) @(negedge clk);
        spi_bits(8'h44, 8, r0);
        spi_bits(8'h00, 4, r0);
        reset = 1'b1; repeat (3) @(negedge clk);
        chk("mrst_err", err_ovf, 0);
        chk("mrst_miso", miso, 0);
        reset = 1'b0; repeat (2) @(negedge clk);
        ss_n = 1'b1; repeat (2*H) @(negedge clk);
        chk("mrst_cts", cts, 1);
        xfer('{8'h44, 8'h00}, rx);
        chk("mrst_rd_cts", rx[1], 8'hFF);
        chk("mrst_err_after", err_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
